// File: rtl/morse_input_frontend_if.sv
// Signal bundle between the Morse input front end and its user: raw button and
// letter select in, encoded symbols, strobes and busy flag out.
interface morse_input_frontend_if;
    logic       button_i;
    logic [2:0] letter_i;
    logic [3:0] morse_char_o;
    logic [2:0] morse_len_o;
    logic       push_o;
    logic       tick_o;
    logic       busy_o;

    modport master (
        output button_i, letter_i,
        input  morse_char_o, morse_len_o, push_o, tick_o, busy_o
    );

    modport slave (
        input  button_i, letter_i,
        output morse_char_o, morse_len_o, push_o, tick_o, busy_o
    );
endinterface

// File: rtl/morse_input_frontend.sv
// Button synchroniser/debouncer, letter-to-Morse encoder, symbol tick generator and
// a small FSM that locks out further presses while a letter is being played.
module morse_input_frontend #(
    parameter int TICK_DIV     = 25_000_000,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    morse_input_frontend_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    logic          sync_meta;
    logic          sync_level;
    logic          stable_level;
    logic          level_prev;
    logic [DW-1:0] deb_count;
    logic [TW-1:0] tick_count;
    logic          press;
    logic          tick;
    logic [3:0]    enc_char;
    logic [2:0]    enc_len;

    state_t        state;
    logic [3:0]    char_reg;
    logic [2:0]    len_reg;
    logic          push_reg;
    logic          busy_reg;
    logic [2:0]    remaining;

    // Any sample agreeing with the accepted level restarts the stability count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_meta    <= 1'b0;
            sync_level   <= 1'b0;
            stable_level <= 1'b0;
            level_prev   <= 1'b0;
            deb_count    <= '0;
        end else begin
            sync_meta  <= bus.button_i;
            sync_level <= sync_meta;
            level_prev <= stable_level;
            if (sync_level == stable_level) begin
                deb_count <= '0;
            end else if (deb_count == DEB_LAST) begin
                stable_level <= sync_level;
                deb_count    <= '0;
            end else begin
                deb_count <= deb_count + 1'b1;
            end
        end
    end

    assign press = stable_level & ~level_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_count <= '0;
        end else if (tick_count == TICK_LAST) begin
            tick_count <= '0;
        end else begin
            tick_count <= tick_count + 1'b1;
        end
    end

    assign tick = (tick_count == TICK_LAST);

    // Symbols are LSB-first, 1 = dash.
    always_comb begin
        enc_char = 4'b0000;
        enc_len  = 3'd1;
        case (bus.letter_i)
            3'd0: begin enc_char = 4'b0010; enc_len = 3'd2; end
            3'd1: begin enc_char = 4'b0001; enc_len = 3'd4; end
            3'd2: begin enc_char = 4'b0101; enc_len = 3'd4; end
            3'd3: begin enc_char = 4'b0001; enc_len = 3'd3; end
            3'd4: begin enc_char = 4'b0000; enc_len = 3'd1; end
            3'd5: begin enc_char = 4'b0100; enc_len = 3'd4; end
            3'd6: begin enc_char = 4'b0011; enc_len = 3'd3; end
            default: begin enc_char = 4'b0000; enc_len = 3'd4; end
        endcase
    end

    // Playback window lasts len+2 ticks, counted only once BUSY is entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            char_reg  <= 4'b0000;
            len_reg   <= 3'd0;
            push_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            remaining <= 3'd0;
        end else begin
            push_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        char_reg  <= enc_char;
                        len_reg   <= enc_len;
                        push_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                        remaining <= enc_len + 3'd2;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (tick) begin
                        if (remaining == 3'd1) begin
                            busy_reg <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            remaining <= remaining - 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.morse_char_o = char_reg;
    assign bus.morse_len_o  = len_reg;
    assign bus.push_o       = push_reg;
    assign bus.busy_o       = busy_reg;
    assign bus.tick_o       = tick;

endmodule
